// File: rtl/hue_calc.sv
// Hue from signed chroma difference, chroma range and max-channel index via an iterative restoring divider.
// Optional: define HUE_ROUND_EN to round the quotient to nearest instead of truncating.
module hue_calc #(
  parameter int W     = 10,
  parameter int HUE_W = 9,
  parameter int DIV_N = W + 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W:0]       num,
  input  logic [W-1:0]     delta,
  input  logic [1:0]       max_index,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [HUE_W-1:0] hue
);

  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

  localparam int CNT_W = $clog2(DIV_N);

  state_t           state;
  logic             sign_q;
  logic [DIV_N-1:0] dq;       // dividend shifting out MSB-first, quotient shifting in at LSB
  logic [W-1:0]     divisor;
  logic [HUE_W-1:0] offset;
  logic [W:0]       rem;
  logic [CNT_W-1:0] cnt;

  logic [W:0]       num_neg;
  logic [W-1:0]     mag;
  logic [DIV_N-1:0] dividend;
  logic [HUE_W-1:0] offset_sel;

  assign num_neg  = -num;
  // Only -2^W has no positive W-bit twin; it saturates to 2^W - 1.
  assign mag      = num[W] ? (num_neg[W] ? {W{1'b1}} : num_neg[W-1:0]) : num[W-1:0];
  assign dividend = DIV_N'(mag) * DIV_N'(60);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    offset_sel = '0;
    case (max_index)
      2'd1:    offset_sel = HUE_W'(120);
      2'd2:    offset_sel = HUE_W'(240);
      default: offset_sel = '0;
    endcase
  end

  logic [W:0] rem_sh;
  logic       rem_ge;
  logic [W:0] rem_nx;

  assign rem_sh = {rem[W-1:0], dq[DIV_N-1]};
  assign rem_ge = rem_sh >= {1'b0, divisor};
  assign rem_nx = rem_ge ? rem_sh - {1'b0, divisor} : rem_sh;

  logic [DIV_N:0]          q_full;
  logic [6:0]              q_sat;
  logic signed [HUE_W+1:0] off_s;
  logic signed [HUE_W+1:0] q_s;
  logic signed [HUE_W+1:0] t;
  logic [HUE_W-1:0]        fix_hue;

  always_comb begin
    q_full = {1'b0, dq};
`ifdef HUE_ROUND_EN
    if (divisor != '0 && {rem, 1'b0} >= {2'b00, divisor})
      q_full = q_full + 1'b1;
`endif
    q_sat   = (q_full > (DIV_N+1)'(60)) ? 7'd60 : q_full[6:0];
    off_s   = $signed({2'b00, offset});
    q_s     = $signed({{(HUE_W-5){1'b0}}, q_sat});
    t       = '0;
    fix_hue = '0;
    if (divisor == '0) begin
      fix_hue = '0;
    end else if (!sign_q) begin
      t       = off_s + q_s;
      fix_hue = t[HUE_W-1:0];
    end else begin
      t = off_s - q_s;
      if (t < 0) t = t + (HUE_W+2)'(360);
      fix_hue = t[HUE_W-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      hue       <= '0;
      sign_q    <= 1'b0;
      dq        <= '0;
      divisor   <= '0;
      offset    <= '0;
      rem       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign_q   <= num[W];
          dq       <= dividend;
          divisor  <= delta;
          offset   <= offset_sel;
          rem      <= '0;
          cnt      <= '0;
          in_ready <= 1'b0;
          state    <= DIV;
        end
        DIV: begin
          rem <= rem_nx;
          dq  <= {dq[DIV_N-2:0], rem_ge};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(DIV_N-1)) state <= FIX;
        end
        FIX: begin
          hue       <= fix_hue;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hue_calc.sv
// Directed-vector bench for hue_calc: per-channel hue, wrap, grey, clamp, rounding, handshake and reset abort.
module tb_hue_calc;

  localparam int W     = 10;
  localparam int HUE_W = 9;
  localparam int LAT   = 17;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W:0]       num = '0;
  logic [W-1:0]     delta = '0;
  logic [1:0]       max_index = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [HUE_W-1:0] hue;

  int n_cmp = 0;
  int n_bad = 0;

  hue_calc #(.W(W), .HUE_W(HUE_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .num(num), .delta(delta), .max_index(max_index),
    .out_valid(out_valid), .out_ready(out_ready), .hue(hue)
  );

  always #5 clk = ~clk;

  // Drives one operation from a negedge and returns the hue and the number of edges
  // from accept to out_valid; lat = 0 and hue = X if the bound expires.
  task automatic run_op(input int n, input int d, input int mi,
                        output logic [HUE_W-1:0] h, output int lat);
    int k;
    h   = 'x;
    lat = 0;
    k   = 0;
    @(negedge clk);
    while (!in_ready && k < 100) begin @(negedge clk); k++; end
    num       = (W+1)'(n);
    delta     = W'(d);
    max_index = 2'(mi);
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    num      = '1;
    delta    = '1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        h   = hue;
        break;
      end
    end
    if (out_ready) begin @(posedge clk); @(negedge clk); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (hue !== '0)       begin n_bad++; $display("FAIL reset_hue got=%0d exp=0", hue); end
    n_cmp++; if (out_valid !== 0)  begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (in_ready !== 1)   begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++; if (out_valid !== 0 || in_ready !== 1)
      begin n_bad++; $display("FAIL idle_quiet got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready); end
  endtask

  task automatic test_basic;
    logic [HUE_W-1:0] h; int lat;
    run_op(100, 200, 0, h, lat);
    n_cmp++; if (h !== 30)    begin n_bad++; $display("FAIL red_hue got=%0d exp=30", h); end
    n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL red_latency got=%0d exp=%0d", lat, LAT); end
    run_op(50, 100, 1, h, lat);
    n_cmp++; if (h !== 150)   begin n_bad++; $display("FAIL green_hue got=%0d exp=150", h); end
    run_op(10, 20, 2, h, lat);
    n_cmp++; if (h !== 270)   begin n_bad++; $display("FAIL blue_hue got=%0d exp=270", h); end
    run_op(100, 200, 3, h, lat);
    n_cmp++; if (h !== 30)    begin n_bad++; $display("FAIL idx3_hue got=%0d exp=30", h); end
  endtask

  task automatic test_neg_wrap;
    logic [HUE_W-1:0] h; int lat;
    run_op(-100, 200, 0, h, lat);
    n_cmp++; if (h !== 330) begin n_bad++; $display("FAIL neg_wrap1 got=%0d exp=330", h); end
    run_op(-60, 60, 0, h, lat);
    n_cmp++; if (h !== 300) begin n_bad++; $display("FAIL neg_wrap2 got=%0d exp=300", h); end
    run_op(-1024, 1023, 0, h, lat);
    n_cmp++; if (h !== 300) begin n_bad++; $display("FAIL most_neg got=%0d exp=300", h); end
    run_op(-30, 60, 1, h, lat);
    n_cmp++; if (h !== 90)  begin n_bad++; $display("FAIL neg_green got=%0d exp=90", h); end
  endtask

  task automatic test_grey_clamp;
    logic [HUE_W-1:0] h; int lat;
    run_op(123, 0, 1, h, lat);
    n_cmp++; if (h !== 0)     begin n_bad++; $display("FAIL grey_hue got=%0d exp=0", h); end
    n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL grey_latency got=%0d exp=%0d", lat, LAT); end
    run_op(300, 100, 1, h, lat);
    n_cmp++; if (h !== 180)   begin n_bad++; $display("FAIL clamp_hue got=%0d exp=180", h); end
  endtask

  task automatic test_round;
    logic [HUE_W-1:0] h; int lat; int e_pos; int e_neg;
`ifdef HUE_ROUND_EN
    e_pos = 9;  e_neg = 351;
`else
    e_pos = 8;  e_neg = 352;
`endif
    run_op(1, 7, 0, h, lat);
    n_cmp++; if (h !== HUE_W'(e_pos)) begin n_bad++; $display("FAIL round_pos got=%0d exp=%0d", h, e_pos); end
    run_op(-1, 7, 0, h, lat);
    n_cmp++; if (h !== HUE_W'(e_neg)) begin n_bad++; $display("FAIL round_neg got=%0d exp=%0d", h, e_neg); end
  endtask

  task automatic test_handshake;
    logic [HUE_W-1:0] h; int lat; int bad_hold; int extra;
    out_ready = 1'b0;
    run_op(100, 200, 0, h, lat);
    n_cmp++; if (h !== 30) begin n_bad++; $display("FAIL hold_first got=%0d exp=30", h); end
    bad_hold = 0;
    num = 11'(-50); delta = 10'd100; max_index = 2'd2; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (hue !== 30 || out_valid !== 1 || in_ready !== 0) bad_hold++;
    end
    n_cmp++; if (bad_hold != 0)
      begin n_bad++; $display("FAIL hold_stable got=%0d bad cycles exp=0", bad_hold); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1 || out_valid !== 0)
      begin n_bad++; $display("FAIL release got ir=%b ov=%b exp ir=1 ov=0", in_ready, out_valid); end
    extra = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    n_cmp++; if (extra != 0)
      begin n_bad++; $display("FAIL ignored_input got=%0d out_valid cycles exp=0", extra); end
  endtask

  task automatic test_reset_mid;
    logic [HUE_W-1:0] h; int lat; int extra;
    @(negedge clk);
    num = 11'd100; delta = 10'd200; max_index = 2'd0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1 || out_valid !== 0)
      begin n_bad++; $display("FAIL abort got ir=%b ov=%b exp ir=1 ov=0", in_ready, out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    n_cmp++; if (extra != 0)
      begin n_bad++; $display("FAIL abort_no_output got=%0d exp=0", extra); end
    run_op(20, 40, 0, h, lat);
    n_cmp++; if (h !== 30) begin n_bad++; $display("FAIL after_abort got=%0d exp=30", h); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_neg_wrap;
    test_grey_clamp;
    test_round;
    test_handshake;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
